// File: rtl/dspl_pkg.sv
// Glyph constants, FSM state type and segment decode helper for the
// display-bus capture monitor. Segment codes are active-low a..g, a in bit 6.
package dspl_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] hex;
  } seg_dec_t;

  // Illegal and blank patterns both yield hex 0.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    r.legal = 1'b1;
    r.blank = 1'b0;
    r.hex   = 4'h0;
    case (seg)
      SEG_0:     r.hex = 4'h0;
      SEG_1:     r.hex = 4'h1;
      SEG_2:     r.hex = 4'h2;
      SEG_3:     r.hex = 4'h3;
      SEG_4:     r.hex = 4'h4;
      SEG_5:     r.hex = 4'h5;
      SEG_6:     r.hex = 4'h6;
      SEG_7:     r.hex = 4'h7;
      SEG_8:     r.hex = 4'h8;
      SEG_9:     r.hex = 4'h9;
      SEG_A:     r.hex = 4'hA;
      SEG_B:     r.hex = 4'hB;
      SEG_C:     r.hex = 4'hC;
      SEG_D:     r.hex = 4'hD;
      SEG_E:     r.hex = 4'hE;
      SEG_F:     r.hex = 4'hF;
      SEG_BLANK: r.blank = 1'b1;
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dspl_scan_capture_seg7_decode.sv
// Combinational a..g (active-low) to {legal, blank, hex} decoder.
// Ports: seg_i[6:0] a..g; legal_o, blank_o, hex_o[3:0].
module seg7_decode
  import dspl_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] hex_o
);

  seg_dec_t dec;

  assign dec     = seg_decode(seg_i);
  assign legal_o = dec.legal;
  assign blank_o = dec.blank;
  assign hex_o   = dec.hex;

endmodule

// File: rtl/dspl_scan_capture.sv
// Monitor for the multiplexed 7-seg bus: samples an/dec_ddp, rebuilds
// 8 digits, dots and blanking, and publishes a frame once all digits are seen.
// Ports: clk, rst (async high), an[7:0], dec_ddp[7:0] in;
// digits[31:0], dots, blank, frame_valid, seg_err, scan_err, scan_stall out.
// Optional DSPL_CAP_STATS_EN adds frame_cnt[15:0] and err_cnt[15:0].
module dspl_scan_capture
  import dspl_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  dec_ddp,
  output logic [31:0] digits,
  output logic [7:0]  dots,
  output logic [7:0]  blank,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        scan_err,
  output logic        scan_stall
`ifdef DSPL_CAP_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

  logic [7:0]    an_m_q, an_s_q, seg_m_q, seg_s_q;
  logic [7:0]    an_lat_q, seg_lat_q;
  logic [2:0]    idx_q, idx_w;
  logic [CW-1:0] cnt_q;
  state_t        st_q;
  logic [7:0]    seen_q, seen_nxt;
  logic          commit_q, multi_q;
  logic [TW-1:0] stall_q;
  logic [31:0]   stg_dig_q, digits_q;
  logic [7:0]    stg_dot_q, stg_blk_q, dots_q, blank_q;
  logic          fv_q, seg_err_q, scan_err_q;
  logic [7:0]    nan;
  logic          onehot, multi, an_chg, seg_chg, eval, sample;
  logic          dec_legal, dec_blank;
  logic [3:0]    dec_hex;

  // Sync regs reset to "all off" so reset release is not seen as a multi-low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_m_q  <= 8'hFF;
      an_s_q  <= 8'hFF;
      seg_m_q <= 8'hFF;
      seg_s_q <= 8'hFF;
    end else begin
      an_m_q  <= an;
      an_s_q  <= an_m_q;
      seg_m_q <= dec_ddp;
      seg_s_q <= seg_m_q;
    end
  end

  assign nan     = ~an_s_q;
  assign onehot  = (|nan) && ((nan & (nan - 8'd1)) == 8'd0);
  assign multi   = (|nan) && !onehot;
  assign an_chg  = an_s_q != an_lat_q;
  assign seg_chg = seg_s_q != seg_lat_q;
  // HOLD and SETTLE fall back into the idle evaluation on any anode change,
  // so the next digit is picked up in the same cycle.
  assign eval    = (st_q == S_IDLE) || an_chg;
  assign sample  = (st_q == S_SETTLE) && !an_chg && !seg_chg
                && (cnt_q == CNT_MAX);
  assign seen_nxt = seen_q | (8'd1 << idx_q);

  always_comb begin
    idx_w = 3'd0;
    for (int i = 0; i < 8; i++)
      if (nan[i]) idx_w = 3'(i);
  end

  seg7_decode u_dec (
    .seg_i   (seg_s_q[7:1]),
    .legal_o (dec_legal),
    .blank_o (dec_blank),
    .hex_o   (dec_hex)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      an_lat_q  <= 8'hFF;
      seg_lat_q <= 8'hFF;
    end else if (eval) begin
      if (onehot) begin
        st_q      <= S_SETTLE;
        cnt_q     <= CW'(1);
        idx_q     <= idx_w;
        an_lat_q  <= an_s_q;
        seg_lat_q <= seg_s_q;
      end else begin
        st_q <= S_IDLE;
      end
    end else if (st_q == S_SETTLE) begin
      if (seg_chg) begin
        cnt_q     <= CW'(1);
        seg_lat_q <= seg_s_q;
      end else if (cnt_q == CNT_MAX) begin
        st_q <= S_HOLD;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_dig_q  <= '0;
      stg_dot_q  <= '0;
      stg_blk_q  <= '0;
      seen_q     <= '0;
      commit_q   <= 1'b0;
      digits_q   <= '0;
      dots_q     <= '0;
      blank_q    <= '0;
      fv_q       <= 1'b0;
      seg_err_q  <= 1'b0;
      scan_err_q <= 1'b0;
      multi_q    <= 1'b0;
      stall_q    <= '0;
    end else begin
      multi_q    <= multi;
      scan_err_q <= multi && !multi_q;
      seg_err_q  <= sample && !dec_legal;
      fv_q       <= commit_q;
      commit_q   <= sample && (seen_nxt == 8'hFF);
      if (sample) begin
        stg_dig_q[4*idx_q +: 4] <= dec_hex;
        stg_dot_q[idx_q]        <= ~seg_s_q[0];
        stg_blk_q[idx_q]        <= dec_legal & dec_blank;
        seen_q                  <= seen_nxt;
      end else if (commit_q) begin
        seen_q <= '0;
      end
      if (commit_q) begin
        digits_q <= stg_dig_q;
        dots_q   <= stg_dot_q;
        blank_q  <= stg_blk_q;
      end
      if (sample)
        stall_q <= '0;
      else if (stall_q != TO_MAX)
        stall_q <= stall_q + TW'(1);
    end
  end

  assign digits      = digits_q;
  assign dots        = dots_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign seg_err     = seg_err_q;
  assign scan_err    = scan_err_q;
  assign scan_stall  = stall_q == TO_MAX;

`ifdef DSPL_CAP_STATS_EN
  logic [15:0] fcnt_q, ecnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      if (fv_q)
        fcnt_q <= fcnt_q + 16'd1;
      if ((seg_err_q || scan_err_q) && ecnt_q != 16'hFFFF)
        ecnt_q <= ecnt_q + 16'd1;
    end
  end

  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;
`endif

endmodule
